// File: rtl/rijndael_inv_keyschedule.sv
// Rijndael key schedule for decryption: expands the cipher key forward once, then
// walks the round keys backwards one per enable, wrapping from round 0 to round NR.
module rijndael_inv_keyschedule #(
  parameter int NK = 4,
  localparam int NB = NK,
  localparam int KEYSIZE = 32 * NK,
  localparam int NR = NK + 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [KEYSIZE-1:0] key_i,
  input  logic               enable_i,
  output logic [32*NB-1:0]   roundkey_o,
  output logic [3:0]         round_o,
  output logic               valid_o,
  output logic               busy_o,
  output logic               last_o
);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_nk_check
    $error("rijndael_inv_keyschedule: NK must be 4, 6 or 8");
  end

  localparam logic [3:0] NR4     = 4'(NR);
  localparam logic [7:0] RCON_NR = (NK == 4) ? 8'h36 : (NK == 6) ? 8'hd8 : 8'h4d;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    StIdle,
    StExpand,
    StReady
  } state_e;

  // Byte b sits at bit offset 8*(255-b) because entry 0 occupies the MSBs.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX[idx +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] xtime_inv(input logic [7:0] x);
    return x[0] ? (((x ^ 8'h1b) >> 1) | 8'h80) : (x >> 1);
  endfunction

  function automatic logic [KEYSIZE-1:0] fwd_step(input logic [KEYSIZE-1:0] k,
                                                  input logic [7:0]         rc);
    logic [31:0]        w [NK];
    logic [31:0]        n [NK];
    logic [KEYSIZE-1:0] r;
    for (int j = 0; j < NK; j++) begin
      w[j] = k[32*(NK-1-j) +: 32];
    end
    n[0] = w[0] ^ sub_word(rot_word(w[NK-1])) ^ {rc, 24'h0};
    for (int j = 1; j < NK; j++) begin
      if (NK == 8 && j == 4) begin
        n[j] = w[j] ^ sub_word(n[3]);
      end else begin
        n[j] = w[j] ^ n[j-1];
      end
    end
    r = '0;
    for (int j = 0; j < NK; j++) begin
      r[32*(NK-1-j) +: 32] = n[j];
    end
    return r;
  endfunction

  // Undo one forward step: w holds round r, n becomes round r-1. Word 4 of the
  // 256-bit schedule was mixed with SubWord of the newer word 3, which is still in w.
  function automatic logic [KEYSIZE-1:0] inv_step(input logic [KEYSIZE-1:0] k,
                                                  input logic [7:0]         rc);
    logic [31:0]        w [NK];
    logic [31:0]        n [NK];
    logic [KEYSIZE-1:0] r;
    for (int j = 0; j < NK; j++) begin
      w[j] = k[32*(NK-1-j) +: 32];
    end
    for (int j = NK - 1; j >= 1; j--) begin
      if (NK == 8 && j == 4) begin
        n[j] = w[j] ^ sub_word(w[3]);
      end else begin
        n[j] = w[j] ^ w[j-1];
      end
    end
    n[0] = w[0] ^ sub_word(rot_word(n[NK-1])) ^ {rc, 24'h0};
    r = '0;
    for (int j = 0; j < NK; j++) begin
      r[32*(NK-1-j) +: 32] = n[j];
    end
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [KEYSIZE-1:0] key_q, key_d;
  logic [KEYSIZE-1:0] dkey_q, dkey_d;
  logic [3:0]         round_q, round_d;
  logic [7:0]         rc_q, rc_d;
  logic [KEYSIZE-1:0] fwd_key, inv_key;

  assign fwd_key = fwd_step(key_q, rc_q);
  assign inv_key = inv_step(key_q, rc_q);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    dkey_d  = dkey_q;
    round_d = round_q;
    rc_d    = rc_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StExpand;
          key_d   = key_i;
          round_d = 4'd0;
          rc_d    = 8'h01;
        end
      end
      StExpand: begin
        key_d   = fwd_key;
        round_d = round_q + 4'd1;
        if (round_q == NR4 - 4'd1) begin
          // rc already holds rcon[NR], which is what the first inverse step needs.
          state_d = StReady;
          dkey_d  = fwd_key;
        end else begin
          rc_d = xtime(rc_q);
        end
      end
      StReady: begin
        if (start_i) begin
          state_d = StExpand;
          key_d   = key_i;
          round_d = 4'd0;
          rc_d    = 8'h01;
        end else if (enable_i) begin
          if (round_q != 4'd0) begin
            key_d   = inv_key;
            round_d = round_q - 4'd1;
            rc_d    = xtime_inv(rc_q);
          end else begin
            key_d   = dkey_q;
            round_d = NR4;
            rc_d    = RCON_NR;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      key_q   <= '0;
      dkey_q  <= '0;
      round_q <= 4'd0;
      rc_q    <= 8'h01;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      dkey_q  <= dkey_d;
      round_q <= round_d;
      rc_q    <= rc_d;
    end
  end

  assign roundkey_o = key_q;
  assign round_o    = round_q;
  assign valid_o    = (state_q == StReady);
  assign busy_o     = (state_q == StExpand);
  assign last_o     = (state_q == StReady) && (round_q == 4'd0);

endmodule

// File: tb/tb_rijndael_inv_keyschedule.sv
// Scoreboard bench for NK=4/6/8 instances checked against a word-wise Rijndael
// key expansion built on a GF(2^8)-derived S-box.
`timescale 1ns / 1ps
module tb_rijndael_inv_keyschedule;

  localparam logic [255:0] KEY_A = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY_B = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] RK10_A = 256'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [255:0] RK9_A = 256'h549932d1f08557681093ed9cbe2c974e;
  localparam logic [255:0] RK10_B = 256'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  typedef struct packed {
    logic [1:0]   sel;
    logic [3:0]   round;
    logic [255:0] key;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start [3];
  logic         enable [3];
  logic [255:0] key_in [3];
  logic [255:0] rk [3];
  logic [3:0]   rnd [3];
  logic         valid [3];
  logic         busy [3];
  logic         last [3];
  logic [127:0] rk4;
  logic [191:0] rk6;
  logic [255:0] rk8;

  int           n_vec = 0;
  int           n_err = 0;
  exp_t         sbq [$];
  exp_t         mon_e;
  logic [7:0]   sb [256];
  logic [255:0] mrk [15];
  int           mround;
  logic [2:0]   vprev = '0;
  logic [2:0]   acc = '0;

  always #5 clk = ~clk;

  rijndael_inv_keyschedule #(.NK(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .key_i(key_in[0][127:0]),
    .enable_i(enable[0]), .roundkey_o(rk4), .round_o(rnd[0]), .valid_o(valid[0]),
    .busy_o(busy[0]), .last_o(last[0])
  );
  rijndael_inv_keyschedule #(.NK(6)) u_dut6 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .key_i(key_in[1][191:0]),
    .enable_i(enable[1]), .roundkey_o(rk6), .round_o(rnd[1]), .valid_o(valid[1]),
    .busy_o(busy[1]), .last_o(last[1])
  );
  rijndael_inv_keyschedule #(.NK(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start[2]), .key_i(key_in[2]),
    .enable_i(enable[2]), .roundkey_o(rk8), .round_o(rnd[2]), .valid_o(valid[2]),
    .busy_o(busy[2]), .last_o(last[2])
  );

  assign rk[0] = {128'h0, rk4};
  assign rk[1] = {64'h0, rk6};
  assign rk[2] = rk8;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] tb_xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = tb_xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    return d[15-n -: 8];
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] tb_sub(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Classic word-by-word expansion; round key r is words r*nk .. r*nk+nk-1.
  task automatic model_expand(input int nk, input logic [255:0] key);
    logic [31:0] w [120];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[32*(nk-1-i) +: 32];
    for (int i = nk; i < nk * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = tb_sub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = tb_xtime(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = tb_sub(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      mrk[r] = '0;
      for (int j = 0; j < nk; j++) mrk[r][32*(nk-1-j) +: 32] = w[r*nk+j];
    end
  endtask

  function automatic logic [255:0] rand_key(input int nk);
    logic [255:0] k;
    logic [255:0] m;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    m = '1;
    m = m >> (256 - 32 * nk);
    return k & m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int sel, input int r);
    exp_t e;
    e.sel   = 2'(sel);
    e.round = 4'(r);
    e.key   = mrk[r];
    sbq.push_back(e);
  endtask

  task automatic do_start(input int sel, input int nk, input logic [255:0] k);
    start[sel]  = 1'b1;
    key_in[sel] = k;
    model_expand(nk, k);
    mround = nk + 6;
    push_exp(sel, mround);
    tick();
    start[sel]  = 1'b0;
    enable[sel] = 1'b0;
  endtask

  task automatic enable_step(input int sel, input int nr);
    enable[sel] = 1'b1;
    if (mround > 0) mround--;
    else mround = nr;
    push_exp(sel, mround);
    tick();
    enable[sel] = 1'b0;
  endtask

  // Waits for valid after a start; optionally throws ignored start/enable pulses at EXPAND.
  task automatic wait_valid(input int sel, input int nr, input bit inject);
    int cnt;
    int bcnt;
    int inj_at;
    cnt    = 0;
    bcnt   = 0;
    inj_at = inject ? int'($urandom_range(1, nr - 1)) : -1;
    while (!valid[sel] && cnt < 4 * nr) begin
      if (busy[sel]) bcnt++;
      if (inject) begin
        enable[sel] = (cnt < nr - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        start[sel]  = (cnt == inj_at);
        if (cnt == inj_at) key_in[sel] = rand_key(nr - 6);
      end
      tick();
      cnt++;
    end
    start[sel]  = 1'b0;
    enable[sel] = 1'b0;
    check_eq("latency", 256'(cnt), 256'(nr));
    check_eq("busy_cycles", 256'(bcnt), 256'(nr));
  endtask

  task automatic check_zero(input int sel);
    check_eq("rst_key", rk[sel], '0);
    check_eq("rst_round", 256'(rnd[sel]), '0);
    check_eq("rst_valid", 256'(valid[sel]), '0);
    check_eq("rst_busy", 256'(busy[sel]), '0);
    check_eq("rst_last", 256'(last[sel]), '0);
  endtask

  task automatic run_random(input int sel, input int nsess);
    int nk;
    int nr;
    int n_en;
    nk = 4 + 2 * sel;
    nr = nk + 6;
    for (int s = 0; s < nsess; s++) begin
      enable[sel] = (s > 0);
      do_start(sel, nk, rand_key(nk));
      wait_valid(sel, nr, 1'b1);
      n_en = $urandom_range(3, 2 * nr + 2);
      for (int i = 0; i < n_en; i++) begin
        enable_step(sel, nr);
        repeat ($urandom_range(0, 2)) tick();
      end
    end
  endtask

  // Pops one expectation each time a round key is presented: entering READY, or an
  // enable accepted on the previous edge.
  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (valid[s] && (!vprev[s] || acc[s])) begin
        if (sbq.size() == 0) begin
          check_eq("sb_underflow", 256'(sbq.size()), 256'd1);
        end else begin
          mon_e = sbq.pop_front();
          check_eq("sb_sel", 256'(s), 256'(mon_e.sel));
          check_eq("sb_round", 256'(rnd[s]), 256'(mon_e.round));
          check_eq("sb_key", rk[s], mon_e.key);
          check_eq("sb_last", 256'(last[s]), 256'(mon_e.round == 4'd0));
        end
      end
      acc[s]   = valid[s] && enable[s] && !start[s] && !rst;
      vprev[s] = valid[s];
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] k;
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      start[s]  = 1'b0;
      enable[s] = 1'b0;
      key_in[s] = '0;
    end
    init_sbox();
    repeat (2) tick();
    for (int s = 0; s < 3; s++) check_zero(s);
    rst = 1'b0;
    tick();

    // Known AES-128 schedule, full walk down plus wrap.
    do_start(0, 4, KEY_A);
    check_eq("a_busy_on", 256'(busy[0]), 256'd1);
    wait_valid(0, 10, 1'b0);
    check_eq("a_r10_round", 256'(rnd[0]), 256'd10);
    check_eq("a_r10_key", rk[0], RK10_A);
    check_eq("a_r10_busy", 256'(busy[0]), 256'd0);
    enable_step(0, 10);
    check_eq("a_r9_round", 256'(rnd[0]), 256'd9);
    check_eq("a_r9_key", rk[0], RK9_A);
    repeat (9) enable_step(0, 10);
    check_eq("a_r0_round", 256'(rnd[0]), 256'd0);
    check_eq("a_r0_last", 256'(last[0]), 256'd1);
    check_eq("a_r0_key", rk[0], KEY_A);
    enable_step(0, 10);
    check_eq("a_wrap_round", 256'(rnd[0]), 256'd10);
    check_eq("a_wrap_key", rk[0], RK10_A);
    check_eq("a_wrap_busy", 256'(busy[0]), 256'd0);
    check_eq("a_wrap_valid", 256'(valid[0]), 256'd1);
    tick();

    do_start(0, 4, KEY_B);
    wait_valid(0, 10, 1'b0);
    check_eq("b_r10_key", rk[0], RK10_B);
    repeat (10) enable_step(0, 10);
    check_eq("b_r0_key", rk[0], KEY_B);

    // Reset in the fifth EXPAND cycle abandons the run.
    k = rand_key(4);
    do_start(0, 4, k);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero(0);
    sbq.delete();
    do_start(0, 4, rand_key(4));
    wait_valid(0, 10, 1'b0);

    run_random(0, 2);
    run_random(1, 3);
    run_random(2, 3);

    repeat (3) tick();
    check_eq("sb_drained", 256'(sbq.size()), 256'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
